reg_file: RTL and testbench



---
 rtl/reg_file_pkg.sv | 8 +
 rtl/reg_file.sv | 50 +++++
 tb/tb_reg_file.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared widths and constants for the processor register file.
package reg_file_pkg;

  localparam int DEF_DATA_W = 16;  // processor word width
  localparam int DEF_ADDR_W = 4;   // register index width
  localparam int REG_ZERO   = 0;   // index of the hardwired-zero register

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// Register file: two combinational read ports, one clocked write port,
// register 0 hardwired to zero.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeValue,
  output logic [DATA_W-1:0] ReadA,
  output logic [DATA_W-1:0] ReadB
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // NOTE: every variable in always_comb gets a default first so no latch is inferred.
  always_comb begin
    regs_d = regs_q;
    if (RegWrite && (writeReg != ZERO_IDX)) begin
      regs_d[writeReg] = writeValue;
    end
  end

  // NOTE: this storage is a flop array, not a RAM macro, so clearing it on reset is intended.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Register 0 is forced to zero at the read mux, so its storage is never observed.
  assign ReadA = (srcA == ZERO_IDX) ? '0 : regs_q[srcA];
  assign ReadB = (srcB == ZERO_IDX) ? '0 : regs_q[srcB];

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: reference model plus expected-value queue.
module tb_reg_file;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        RegWrite;
  logic [3:0]  srcA, srcB, writeReg;
  logic [15:0] writeValue;
  logic [15:0] ReadA, ReadB;

  logic [15:0] model [16];
  logic [15:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  reg_file #(.DATA_W(16), .ADDR_W(4)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .RegWrite   (RegWrite),
    .srcA       (srcA),
    .srcB       (srcB),
    .writeReg   (writeReg),
    .writeValue (writeValue),
    .ReadA      (ReadA),
    .ReadB      (ReadB)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_rd(input logic [3:0] idx);
    return (idx == 4'd0) ? 16'h0000 : model[idx];
  endfunction

  // Drive read indices, queue the model's expectation, then compare the outputs.
  task automatic read_chk(input string tag, input logic [3:0] a, input logic [3:0] b);
    srcA = a;
    srcB = b;
    exp_q.push_back(model_rd(a));
    exp_q.push_back(model_rd(b));
    #1;
    if (exp_q.size() < 2) begin
      check({tag, "_queue"}, 16'(exp_q.size()), 16'd2);
    end else begin
      check({tag, "_A"}, ReadA, exp_q.pop_front());
      check({tag, "_B"}, ReadB, exp_q.pop_front());
    end
  endtask

  // Advance one rising edge, updating the model from the inputs seen there.
  task automatic step();
    @(posedge CLK);
    if (!RST_N) begin
      for (int i = 0; i < 16; i++) model[i] = 16'h0000;
    end else if (RegWrite && writeReg != 4'd0) begin
      model[writeReg] = writeValue;
    end
    #1;
  endtask

  task automatic drive_wr(input logic we, input logic [3:0] wr, input logic [15:0] val);
    RegWrite   = we;
    writeReg   = wr;
    writeValue = val;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 16'hxxxx;
    RST_N = 1'b0;
    srcA  = '0;
    srcB  = '0;
    drive_wr(1'b0, 4'd0, 16'h0000);

    // 1. Reset for two edges, then sweep all indices.
    step();
    step();
    RST_N = 1'b1;
    for (int i = 0; i < 16; i++) begin
      read_chk($sformatf("reset_r%0d", i), 4'(i), 4'(15 - i));
    end

    // 2. Basic write, no same-cycle bypass.
    drive_wr(1'b1, 4'd1, 16'hABCD);
    read_chk("wr_pre", 4'd1, 4'd1);
    check("wr_pre_const", ReadA, 16'h0000);
    step();
    drive_wr(1'b0, 4'd0, 16'h0000);
    read_chk("wr_post", 4'd1, 4'd0);
    check("wr_post_const", ReadA, 16'hABCD);

    // 3. Writes to register 0 are discarded without side effects.
    drive_wr(1'b1, 4'd0, 16'h2030);
    step();
    drive_wr(1'b0, 4'd0, 16'h0000);
    read_chk("r0_protect", 4'd0, 4'd1);
    check("r0_protect_r1", ReadB, 16'hABCD);

    // 4. Enable gating.
    drive_wr(1'b0, 4'd2, 16'hABCD);
    repeat (3) step();
    read_chk("we_gate", 4'd2, 4'd2);
    check("we_gate_const", ReadA, 16'h0000);

    // 5. Back-to-back overwrite, both ports on the same register.
    drive_wr(1'b1, 4'd15, 16'h1234);
    step();
    drive_wr(1'b1, 4'd15, 16'hFFFF);
    read_chk("ovw_first", 4'd15, 4'd15);
    check("ovw_first_const", ReadB, 16'h1234);
    step();
    drive_wr(1'b0, 4'd0, 16'h0000);
    read_chk("ovw_second", 4'd15, 4'd15);
    check("ovw_second_const", ReadA, 16'hFFFF);

    // Random writes and reads against the model.
    for (int i = 0; i < 40; i++) begin
      drive_wr(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom));
      read_chk($sformatf("rnd_pre%0d", i), 4'($urandom_range(0, 15)), writeReg);
      step();
      read_chk($sformatf("rnd_post%0d", i), writeReg, 4'($urandom_range(0, 15)));
    end

    // 6. Reset overrides a simultaneous write.
    drive_wr(1'b1, 4'd1, 16'hABCD);
    step();
    drive_wr(1'b1, 4'd3, 16'h5555);
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    drive_wr(1'b0, 4'd0, 16'h0000);
    read_chk("rst_mid", 4'd3, 4'd1);
    check("rst_mid_r3", ReadA, 16'h0000);
    check("rst_mid_r1", ReadB, 16'h0000);

    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_reg_file
